// File: rtl/fwrisc_prog_loader.sv
// UART program loader for the fwrisc core: parses an A5/LEN/payload frame into instruction-memory word writes.
// Optional trailing XOR checksum byte is enabled by defining FWRISC_PROG_LOADER_CSUM_EN.
`timescale 1ns/1ps
module fwrisc_prog_loader #(
  parameter int unsigned MEM_ADDR_W     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  program_receiving,
  output logic                  program_ov,
  output logic                  program_done,
  output logic                  load_err
);

  localparam int unsigned IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] CAPACITY = 33'(1) << MEM_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA,
`ifdef FWRISC_PROG_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE, S_OVF
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [23:0]           word_q, word_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  receiving_q, receiving_d;
  logic                  ov_q, ov_d;
  logic                  done_q, done_d;
  logic                  load_err_q, load_err_d;
`ifdef FWRISC_PROG_LOADER_CSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  active_c;
  logic                  finish_c;
  logic [15:0]           len_c;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_reset_d = core_reset_q;
    ov_d         = ov_q;
    done_d       = done_q;
    load_err_d   = 1'b0;
    finish_c     = 1'b0;
    len_c        = {rx_data, len_lo_q};
`ifdef FWRISC_PROG_LOADER_CSUM_EN
    csum_d       = csum_q;
    active_c     = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
`else
    active_c     = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
`endif

    // Address advances the cycle after each write strobe.
    if (mem_we_q) mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == 8'hA5) begin
          state_d    = S_LEN0;
          mem_addr_d = '0;
          byte_cnt_d = '0;
`ifdef FWRISC_PROG_LOADER_CSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_valid) begin
          if ({17'b0, len_c} > CAPACITY) begin
            state_d = S_OVF;
            ov_d    = 1'b1;
          end else if (len_c == 16'd0) begin
            finish_c = 1'b1;
          end else begin
            state_d      = S_DATA;
            words_left_d = len_c;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
`ifdef FWRISC_PROG_LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: begin
              mem_we_d     = 1'b1;
              mem_wdata_d  = {rx_data, word_q};
              words_left_d = words_left_q - 16'd1;
              if (words_left_q == 16'd1) finish_c = 1'b1;
            end
          endcase
        end
      end
`ifdef FWRISC_PROG_LOADER_CSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
          end else begin
            state_d    = S_IDLE;
            load_err_d = 1'b1;
            mem_addr_d = '0;
            byte_cnt_d = '0;
          end
        end
      end
`endif
      default: ;
    endcase

    if (finish_c) begin
`ifdef FWRISC_PROG_LOADER_CSUM_EN
      state_d      = S_CSUM;
`else
      state_d      = S_DONE;
      done_d       = 1'b1;
      core_reset_d = 1'b0;
`endif
    end

    // Idle timeout; an arriving byte always wins over expiry.
    if (active_c && !rx_valid) begin
      if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        state_d    = S_IDLE;
        load_err_d = 1'b1;
        mem_addr_d = '0;
        byte_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end

`ifdef FWRISC_PROG_LOADER_CSUM_EN
    receiving_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                  (state_d == S_DATA) || (state_d == S_CSUM);
`else
    receiving_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      receiving_q  <= 1'b0;
      ov_q         <= 1'b0;
      done_q       <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef FWRISC_PROG_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_reset_q <= core_reset_d;
      receiving_q  <= receiving_d;
      ov_q         <= ov_d;
      done_q       <= done_d;
      load_err_q   <= load_err_d;
`ifdef FWRISC_PROG_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign core_reset        = core_reset_q;
  assign program_receiving = receiving_q;
  assign program_ov        = ov_q;
  assign program_done      = done_q;
  assign load_err          = load_err_q;

endmodule

// File: tb/tb_fwrisc_prog_loader.sv
// Directed self-checking bench for fwrisc_prog_loader (MEM_ADDR_W=12, TIMEOUT_CYCLES=100).
`timescale 1ns/1ps
module tb_fwrisc_prog_loader;
  localparam int unsigned MEM_ADDR_W = 12;
  localparam int unsigned TIMEOUT    = 100;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  core_reset;
  logic                  program_receiving;
  logic                  program_ov;
  logic                  program_done;
  logic                  load_err;

  int n_pass  = 0;
  int n_total = 0;
  int we_cnt  = 0;
  logic [MEM_ADDR_W-1:0] last_addr = '0;
  logic [31:0]           last_data = '0;

  fwrisc_prog_loader #(.MEM_ADDR_W(MEM_ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .program_receiving(program_receiving),
    .program_ov(program_ov), .program_done(program_done), .load_err(load_err)
  );

  always #5 clock = ~clock;

  // Write log, sampled just after the edge.
  always @(posedge clock) begin
    #1;
    if (mem_we === 1'b1) begin
      we_cnt++;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_word_frame(input logic [31:0] w);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
`ifdef FWRISC_PROG_LOADER_CSUM_EN
    send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clock);
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 12'h000) $display("FAIL rst_mem_addr got %h want 000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset got %b want 1", core_reset); else n_pass++;
    n_total++; if (program_receiving !== 1'b0) $display("FAIL rst_receiving got %b want 0", program_receiving); else n_pass++;
    n_total++; if (program_ov !== 1'b0) $display("FAIL rst_ov got %b want 0", program_ov); else n_pass++;
    n_total++; if (program_done !== 1'b0) $display("FAIL rst_done got %b want 0", program_done); else n_pass++;
    n_total++; if (load_err !== 1'b0) $display("FAIL rst_load_err got %b want 0", load_err); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    int w0;
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    n_total++; if (mem_we !== 1'b1) $display("FAIL basic_we0 got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 12'h000) $display("FAIL basic_addr0 got %h want 000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h12345678) $display("FAIL basic_data0 got %h want 12345678", mem_wdata); else n_pass++;
    n_total++; if (program_receiving !== 1'b1) $display("FAIL basic_receiving got %b want 1", program_receiving); else n_pass++;
    n_total++; if (program_done !== 1'b0) $display("FAIL basic_early_done got %b want 0", program_done); else n_pass++;
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    n_total++; if (mem_we !== 1'b1) $display("FAIL basic_we1 got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 12'h001) $display("FAIL basic_addr1 got %h want 001", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL basic_data1 got %h want deadbeef", mem_wdata); else n_pass++;
`ifdef FWRISC_PROG_LOADER_CSUM_EN
    send_byte(8'h2A);
`endif
    n_total++; if (program_done !== 1'b1) $display("FAIL basic_done got %b want 1", program_done); else n_pass++;
    n_total++; if (core_reset !== 1'b0) $display("FAIL basic_core_reset got %b want 0", core_reset); else n_pass++;
    n_total++; if (program_receiving !== 1'b0) $display("FAIL basic_recv_after got %b want 0", program_receiving); else n_pass++;
    send_word_frame(32'h44332211);
    n_total++; if (we_cnt - w0 !== 2) $display("FAIL basic_write_count got %0d want 2", we_cnt - w0); else n_pass++;
    n_total++; if (program_done !== 1'b1) $display("FAIL basic_done_sticky got %b want 1", program_done); else n_pass++;
  endtask

  task automatic test_len_zero();
    int w0;
    do_reset();
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef FWRISC_PROG_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    n_total++; if (program_done !== 1'b1) $display("FAIL len0_done got %b want 1", program_done); else n_pass++;
    n_total++; if (we_cnt !== w0) $display("FAIL len0_writes got %0d want %0d", we_cnt, w0); else n_pass++;
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    n_total++; if (program_ov !== 1'b1) $display("FAIL ovf_flag got %b want 1", program_ov); else n_pass++;
    n_total++; if (program_receiving !== 1'b0) $display("FAIL ovf_receiving got %b want 0", program_receiving); else n_pass++;
    send_word_frame(32'h55667788);
    n_total++; if (we_cnt !== w0) $display("FAIL ovf_writes got %0d want %0d", we_cnt, w0); else n_pass++;
    n_total++; if (program_ov !== 1'b1) $display("FAIL ovf_sticky got %b want 1", program_ov); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL ovf_core_reset got %b want 1", core_reset); else n_pass++;
    n_total++; if (program_done !== 1'b0) $display("FAIL ovf_done got %b want 0", program_done); else n_pass++;
    // Exactly full memory is legal.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    n_total++; if (program_ov !== 1'b0) $display("FAIL full_len_ov got %b want 0", program_ov); else n_pass++;
    n_total++; if (program_receiving !== 1'b1) $display("FAIL full_len_recv got %b want 1", program_receiving); else n_pass++;
  endtask

  task automatic test_timeout();
    int w0, hit, extra;
    do_reset();
    w0  = we_cnt;
    hit = -1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (load_err === 1'b1) begin hit = i; break; end
    end
    n_total++; if (hit !== 100) $display("FAIL timeout_cycle got %0d want 100", hit); else n_pass++;
    n_total++; if (program_receiving !== 1'b0) $display("FAIL timeout_recv got %b want 0", program_receiving); else n_pass++;
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (load_err === 1'b1) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL timeout_single_pulse got %0d extra want 0", extra); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL timeout_core_reset got %b want 1", core_reset); else n_pass++;
    send_word_frame(32'hCAFEF00D);
    n_total++; if (we_cnt - w0 !== 1) $display("FAIL retry_count got %0d want 1", we_cnt - w0); else n_pass++;
    n_total++; if (last_addr !== 12'h000) $display("FAIL retry_addr got %h want 000", last_addr); else n_pass++;
    n_total++; if (last_data !== 32'hCAFEF00D) $display("FAIL retry_data got %h want cafef00d", last_data); else n_pass++;
    n_total++; if (program_done !== 1'b1) $display("FAIL retry_done got %b want 1", program_done); else n_pass++;
  endtask

  task automatic test_leading_garbage();
    int w0;
    do_reset();
    w0 = we_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    n_total++; if (program_receiving !== 1'b0) $display("FAIL garbage_recv got %b want 0", program_receiving); else n_pass++;
    send_word_frame(32'h0BADC0DE);
    n_total++; if (we_cnt - w0 !== 1) $display("FAIL garbage_count got %0d want 1", we_cnt - w0); else n_pass++;
    n_total++; if (last_addr !== 12'h000) $display("FAIL garbage_addr got %h want 000", last_addr); else n_pass++;
    n_total++; if (last_data !== 32'h0BADC0DE) $display("FAIL garbage_data got %h want 0badc0de", last_data); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int w0, errs;
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    n_total++; if (mem_wdata !== 32'h44332211) $display("FAIL mid_first_word got %h want 44332211", mem_wdata); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    w0 = we_cnt;
    n_total++; if (mem_addr !== 12'h000) $display("FAIL mid_rst_addr got %h want 000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h0) $display("FAIL mid_rst_wdata got %h want 0", mem_wdata); else n_pass++;
    n_total++; if (program_receiving !== 1'b0) $display("FAIL mid_rst_recv got %b want 0", program_receiving); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL mid_rst_core_reset got %b want 1", core_reset); else n_pass++;
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (load_err === 1'b1) errs++;
    end
    n_total++; if (errs !== 0) $display("FAIL mid_rst_load_err got %0d pulses want 0", errs); else n_pass++;
    send_word_frame(32'h89ABCDEF);
    n_total++; if (we_cnt - w0 !== 1) $display("FAIL mid_retry_count got %0d want 1", we_cnt - w0); else n_pass++;
    n_total++; if (last_addr !== 12'h000) $display("FAIL mid_retry_addr got %h want 000", last_addr); else n_pass++;
    n_total++; if (last_data !== 32'h89ABCDEF) $display("FAIL mid_retry_data got %h want 89abcdef", last_data); else n_pass++;
  endtask

`ifdef FWRISC_PROG_LOADER_CSUM_EN
  task automatic test_checksum();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    n_total++; if (program_receiving !== 1'b1) $display("FAIL csum_wait_recv got %b want 1", program_receiving); else n_pass++;
    send_byte(8'h0F);
    n_total++; if (program_done !== 1'b1) $display("FAIL csum_ok_done got %b want 1", program_done); else n_pass++;
    n_total++; if (core_reset !== 1'b0) $display("FAIL csum_ok_core_reset got %b want 0", core_reset); else n_pass++;
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    n_total++; if (load_err !== 1'b1) $display("FAIL csum_bad_err got %b want 1", load_err); else n_pass++;
    n_total++; if (program_done !== 1'b0) $display("FAIL csum_bad_done got %b want 0", program_done); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL csum_bad_core_reset got %b want 1", core_reset); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_len_zero();
    test_overflow();
    test_timeout();
    test_leading_garbage();
    test_reset_mid_load();
`ifdef FWRISC_PROG_LOADER_CSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
